// File: rtl/gpio_link_pkg.sv
// ---------------------------------------------------------------------------
// gpio_link_pkg
// Shared definitions for the 32-bit GPIO command link: word/opcode widths,
// opcode constants, the master FSM state encoding, the idle word and a small
// helper used to size counters.
// ---------------------------------------------------------------------------
package gpio_link_pkg;

    localparam int GPIO_WIDTH  = 32;
    localparam int OP_WIDTH    = 4;
    localparam int PAYLD_WIDTH = GPIO_WIDTH - OP_WIDTH;

    localparam logic [OP_WIDTH-1:0] OP_NOP      = 4'h0;
    localparam logic [OP_WIDTH-1:0] OP_ADC_RD   = 4'h1;
    localparam logic [OP_WIDTH-1:0] OP_DAC_GPIO = 4'h2;

    // Word driven on GPIO_IN whenever no command is in flight.
    localparam logic [GPIO_WIDTH-1:0] IDLE_WORD = '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_POLL   = 3'd2,
        S_RESP   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gpio_cmd_master_if.sv
// ---------------------------------------------------------------------------
// gpio_cmd_master_if
// Bundles the command channel, the response channel and the GPIO word pair.
//
// Handshake rule for both cmd_* and rsp_*: a transfer happens on a rising
// clock edge where valid and ready are both high. The source holds valid and
// its payload stable until that edge; ready never depends combinationally on
// valid.
//
// Modports:
//   master - the gpio_cmd_master side (accepts commands, produces replies,
//            drives gpio_in, reads gpio_out)
//   slave  - the environment side (host bridge + GPIO box)
// ---------------------------------------------------------------------------
interface gpio_cmd_master_if;
    import gpio_link_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [OP_WIDTH-1:0]    cmd_op;
    logic [PAYLD_WIDTH-1:0] cmd_payld;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [GPIO_WIDTH-1:0]  rsp_data;
    logic                   rsp_tmo;
    logic                   busy;
    logic [GPIO_WIDTH-1:0]  gpio_in;
    logic [GPIO_WIDTH-1:0]  gpio_out;

    modport master (
        input  cmd_valid, cmd_op, cmd_payld, rsp_ready, gpio_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_tmo, busy, gpio_in
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_payld, rsp_ready, gpio_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_tmo, busy, gpio_in
    );

endinterface

// File: rtl/gpio_sync.sv
// ---------------------------------------------------------------------------
// gpio_sync
// Per-bit flop chain that brings the GPIO box reply word into the local
// clock domain. STAGES = 0 turns it into a wire for a same-clock box.
//
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset, clears every stage
//   i_d     - raw input word
//   o_q     - synchronised word (i_d delayed by STAGES cycles)
// ---------------------------------------------------------------------------
module gpio_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_chain
            logic [WIDTH-1:0] r_chain [STAGES];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_chain[i] <= '0;
                    end
                end else begin
                    r_chain[0] <= i_d;
                    for (int i = 1; i < STAGES; i++) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                end
            end

            assign o_q = r_chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/gpio_cmd_master.sv
// ---------------------------------------------------------------------------
// gpio_cmd_master
// Initiator end of the GPIO command link. Takes {op,payload} from the local
// host over cmd valid/ready, drives the word on gpio_in, waits a settle time,
// polls the (synchronised) gpio_out reply until its opcode field echoes the
// command opcode, and returns the captured reply over rsp valid/ready. If no
// echo arrives within TIMEOUT_CYCLES polls, the last sample is returned with
// rsp_tmo set. An all-zero word is driven for GAP_CYCLES after each command so
// the box sees a fresh edge on every command.
//
// Ports:
//   i_clk        - clock, rising edge
//   i_rst_n      - asynchronous active-low reset
//   io_bus       - gpio_cmd_master_if.master (cmd, rsp, busy, gpio_in/out)
//   o_dbg_state  - current FSM state
// ---------------------------------------------------------------------------
module gpio_cmd_master
    import gpio_link_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 2,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    gpio_cmd_master_if.master       io_bus,
    output state_t                  o_dbg_state
);

    // One shared counter serves settle, poll and gap phases; it is sized for
    // the largest of the three so it can never wrap.
    localparam int CNT_MAX = max3(SETTLE_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [OP_WIDTH-1:0]   r_op;
    logic [GPIO_WIDTH-1:0] r_gpio_in;
    logic [GPIO_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_tmo;

    logic [GPIO_WIDTH-1:0] w_sample;
    logic [OP_WIDTH-1:0]   w_sample_op;
    logic                  w_echo;

    gpio_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (GPIO_WIDTH)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (io_bus.gpio_out),
        .o_q     (w_sample)
    );

    assign w_sample_op = w_sample[GPIO_WIDTH-1 -: OP_WIDTH];
    assign w_echo      = (w_sample_op == r_op);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= OP_NOP;
            r_gpio_in  <= IDLE_WORD;
            r_rsp_data <= '0;
            r_rsp_tmo  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // cmd_ready is high throughout IDLE, so valid alone means
                    // a transfer. NOP commands are consumed without effect.
                    if (io_bus.cmd_valid && (io_bus.cmd_op != OP_NOP)) begin
                        r_op      <= io_bus.cmd_op;
                        r_gpio_in <= {io_bus.cmd_op, io_bus.cmd_payld};
                        r_cnt     <= '0;
                        r_state   <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_POLL;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_POLL: begin
                    // Echo is tested first so a match on the final poll
                    // still counts as a good reply.
                    if (w_echo) begin
                        r_rsp_data <= w_sample;
                        r_rsp_tmo  <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_RESP;
                    end else if (r_cnt == TMO_LAST) begin
                        r_rsp_data <= w_sample;
                        r_rsp_tmo  <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    // Waits indefinitely for the consumer; gpio_in stays held.
                    if (io_bus.rsp_ready) begin
                        r_gpio_in <= IDLE_WORD;
                        r_cnt     <= '0;
                        r_state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_cnt     <= '0;
                    r_gpio_in <= IDLE_WORD;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode the state register only (no path from cmd_valid).
    assign io_bus.cmd_ready = (r_state == S_IDLE);
    assign io_bus.busy      = (r_state != S_IDLE);
    assign io_bus.rsp_valid = (r_state == S_RESP);
    assign io_bus.rsp_data  = r_rsp_data;
    assign io_bus.rsp_tmo   = r_rsp_tmo;
    assign io_bus.gpio_in   = r_gpio_in;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_gpio_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_gpio_cmd_master
// Directed bench for gpio_cmd_master with SETTLE=2, TIMEOUT=4, GAP=2,
// SYNC_STAGES=2. A small GPIO box model answers a nonzero gpio_in with a
// programmable reply word a programmable number of cycles later.
// Latency figures below count clock edges from the command-accept edge to
// the edge after which rsp_valid is seen: with the box answering 3 cycles
// after gpio_in changes, the two sync stages put the echo on the third poll
// (5 edges); answering after 4 cycles puts it on the fourth and last poll
// (6 edges), the same point at which a timeout is declared.
// ---------------------------------------------------------------------------
module tb_gpio_cmd_master;
    import gpio_link_pkg::*;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_cmd_master_if ifc ();
    state_t dbg_state;

    gpio_cmd_master #(
        .SETTLE_CYCLES  (2),
        .TIMEOUT_CYCLES (4),
        .GAP_CYCLES     (2),
        .SYNC_STAGES    (2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .io_bus      (ifc.master),
        .o_dbg_state (dbg_state)
    );

    // GPIO box model: reply appears model_delay cycles after gpio_in goes
    // nonzero, and drops back to zero whenever gpio_in is idle.
    bit          model_en    = 1'b0;
    int          model_delay = 3;
    logic [31:0] model_reply = '0;
    int          m_cnt       = 0;

    always @(negedge clk) begin
        if (!model_en || (ifc.gpio_in == 32'h0)) begin
            m_cnt        = 0;
            ifc.gpio_out = 32'h0;
        end else begin
            m_cnt++;
            if (m_cnt >= model_delay) ifc.gpio_out = model_reply;
        end
    end

    // scoreboard
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [27:0] payld, output int t_acc);
        bit ok;
        bit seen;
        seen = 1'b0;
        t_acc = -1;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_payld = payld;
        for (int i = 0; i < 50; i++) begin
            ok = ifc.cmd_ready;
            tick();
            if (ok) begin
                t_acc = cyc;
                seen  = 1'b1;
                break;
            end
        end
        ifc.cmd_valid = 1'b0;
        check("cmd_accepted", 32'(seen), 32'd1);
    endtask

    task automatic wait_rsp(output logic [31:0] data, output logic tmo,
                            output int t_rsp, output int polls);
        bit seen;
        seen  = 1'b0;
        polls = 0;
        t_rsp = -1;
        for (int i = 0; i < 200; i++) begin
            if (ifc.rsp_valid) begin
                t_rsp = cyc;
                seen  = 1'b1;
                break;
            end
            if (dbg_state == S_POLL) polls++;
            tick();
        end
        check("rsp_seen", 32'(seen), 32'd1);
        data = ifc.rsp_data;
        tmo  = ifc.rsp_tmo;
    endtask

    // Accept the pending reply and check the idle gap that follows.
    task automatic consume_and_gap(input string tag);
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        check({tag, "_rsp_drop"},  32'(ifc.rsp_valid), 32'd0);
        check({tag, "_gap0_gpio"}, ifc.gpio_in,        32'h0);
        check({tag, "_gap0_rdy"},  32'(ifc.cmd_ready), 32'd0);
        tick();
        check({tag, "_gap1_gpio"}, ifc.gpio_in,        32'h0);
        check({tag, "_gap1_busy"}, 32'(ifc.busy),      32'd1);
        tick();
        check({tag, "_idle_rdy"},  32'(ifc.cmd_ready), 32'd1);
        check({tag, "_idle_busy"}, 32'(ifc.busy),      32'd0);
    endtask

    logic [31:0] r_data;
    logic        r_tmo;
    int          t0, t1, t_e, t_rsp, polls;
    logic [3:0]  ops6  [3] = '{4'h1, 4'h2, 4'h1};
    logic [27:0] pay6  [3] = '{28'h0000111, 28'h0000222, 28'h0000333};
    logic [31:0] rep6  [3] = '{32'h1111_0001, 32'h2222_0002, 32'h1333_0003};

    initial begin
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = '0;
        ifc.cmd_payld = '0;
        ifc.rsp_ready = 1'b0;

        // reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_gpio_in",  ifc.gpio_in,          32'h0);
        check("rst_cmd_rdy",  32'(ifc.cmd_ready),   32'd1);
        check("rst_rsp_vld",  32'(ifc.rsp_valid),   32'd0);
        check("rst_rsp_tmo",  32'(ifc.rsp_tmo),     32'd0);
        check("rst_rsp_data", ifc.rsp_data,         32'h0);
        check("rst_busy",     32'(ifc.busy),        32'd0);
        check("rst_state",    32'(dbg_state),       32'(S_IDLE));
        rst_n = 1'b1;
        tick();

        // echo
        model_en = 1'b1; model_delay = 3; model_reply = 32'h1666_7775;
        send_cmd(4'h1, 28'h4389418, t0);
        check("echo_gpio_drv", ifc.gpio_in, 32'h1438_9418);
        wait_rsp(r_data, r_tmo, t_rsp, polls);
        check("echo_data",     r_data,          32'h1666_7775);
        check("echo_tmo",      32'(r_tmo),      32'd0);
        check("echo_latency",  32'(t_rsp - t0), 32'd5);
        check("echo_gpio_hld", ifc.gpio_in,     32'h1438_9418);
        consume_and_gap("echo");

        // timeout
        model_en = 1'b0;
        send_cmd(4'h1, 28'h0000055, t0);
        wait_rsp(r_data, r_tmo, t_rsp, polls);
        check("tmo_flag",    32'(r_tmo),      32'd1);
        check("tmo_data",    r_data,          32'h0);
        check("tmo_latency", 32'(t_rsp - t0), 32'd6);
        check("tmo_polls",   32'(polls),      32'd4);
        consume_and_gap("tmo");

        // backpressure
        model_en = 1'b1; model_delay = 3; model_reply = 32'h2ABC_DEF0;
        send_cmd(4'h2, 28'h7776666, t0);
        wait_rsp(r_data, r_tmo, t_rsp, polls);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 4'h1;
        ifc.cmd_payld = 28'h0000123;
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_vld",  32'(ifc.rsp_valid), 32'd1);
            check("bp_rsp_data", ifc.rsp_data,       32'h2ABC_DEF0);
            check("bp_gpio_in",  ifc.gpio_in,        32'h2777_6666);
            check("bp_cmd_rdy",  32'(ifc.cmd_ready), 32'd0);
            tick();
        end
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        t_e = cyc;
        model_reply = 32'h1000_0123;
        send_cmd(4'h1, 28'h0000123, t1);
        check("bp_accept_after_gap", 32'(t1 - t_e), 32'd3);
        check("bp_gpio2",            ifc.gpio_in,   32'h1000_0123);
        wait_rsp(r_data, r_tmo, t_rsp, polls);
        check("bp_data2", r_data,     32'h1000_0123);
        check("bp_tmo2",  32'(r_tmo), 32'd0);
        consume_and_gap("bp");

        // NOP drop, then echo on the final poll
        send_cmd(OP_NOP, 28'hFFFFFFF, t0);
        for (int i = 0; i < 3; i++) begin
            check("nop_gpio_in", ifc.gpio_in,        32'h0);
            check("nop_busy",    32'(ifc.busy),      32'd0);
            check("nop_rsp_vld", 32'(ifc.rsp_valid), 32'd0);
            tick();
        end
        model_en = 1'b1; model_delay = 4; model_reply = 32'h2000_ABCD;
        send_cmd(OP_DAC_GPIO, 28'h0000ABC, t0);
        wait_rsp(r_data, r_tmo, t_rsp, polls);
        check("late_tmo",     32'(r_tmo),      32'd0);
        check("late_data",    r_data,          32'h2000_ABCD);
        check("late_latency", 32'(t_rsp - t0), 32'd6);
        check("late_polls",   32'(polls),      32'd4);
        consume_and_gap("late");

        // back-to-back ops 1,2,1
        model_delay = 3;
        for (int k = 0; k < 3; k++) begin
            model_reply = rep6[k];
            exp_q.push_back(rep6[k]);
            send_cmd(ops6[k], pay6[k], t0);
            check("b2b_gpio_in", ifc.gpio_in, {ops6[k], pay6[k]});
            wait_rsp(r_data, r_tmo, t_rsp, polls);
            check("b2b_data",    r_data,          exp_q.pop_front());
            check("b2b_tmo",     32'(r_tmo),      32'd0);
            check("b2b_latency", 32'(t_rsp - t0), 32'd5);
            consume_and_gap("b2b");
        end

        // reset mid-POLL
        model_en = 1'b0;
        send_cmd(4'h1, 28'h4389418, t0);
        tick();
        tick();
        check("mid_state",   32'(dbg_state), 32'(S_POLL));
        check("mid_gpio_in", ifc.gpio_in,    32'h1438_9418);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gpio_in", ifc.gpio_in,        32'h0);
        check("arst_busy",    32'(ifc.busy),      32'd0);
        check("arst_rsp_vld", 32'(ifc.rsp_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_cmd_rdy", 32'(ifc.cmd_ready), 32'd1);
        check("rel_state",   32'(dbg_state),     32'(S_IDLE));
        for (int i = 0; i < 8; i++) tick();
        check("rel_no_rsp",  32'(ifc.rsp_valid), 32'd0);
        check("rel_gpio_in", ifc.gpio_in,        32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
